load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the RV32I ALU. Takes the ALU result as the effective address, plus rs2 data and funct3, and runs one data-memory transaction over a req/gnt/rvalid handshake. Builds byte enables and lane-replicated write data, then sign- or zero-extends load data. Flags misaligned or illegal accesses without touching memory. Returns a one-cycle `done` to the pipeline control.

## Interface
- dataW, 32, datapath width; only 32 is supported
- Clock  in  1  system clock; all state updates on the rising edge
- nReset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store (SB/SH/SW), 0 = load
- funct3  in  3  RV32I width/sign code (0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU)
- addr  in  dataW  effective address (ALU result)
- wdata  in  dataW  store data (rs2)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done; access was not performed
- rdata  out  dataW  extended load result; holds until the next successful load
- mem_req  out  1  memory request
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  dataW  word-aligned address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  dataW  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid on mem_rdata
- mem_rdata  in  dataW  memory read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Every output is driven from a register.
- IDLE + start:
  - Capture is_store, funct3, addr[1:0] and all memory outputs.
  - Legal and aligned → REQ.
  - Otherwise → DONE with misaligned = 1.
- Fault conditions:
  - H/HU/SH with addr[0] = 1.
  - W/SW with addr[1:0] ≠ 0.
  - Load funct3 ∈ {3, 6, 7}.
  - Store funct3 ≥ 3.
- REQ:
  - mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_gnt.
  - On mem_gnt, mem_req drops the next cycle.
  - Store → DONE.
  - Load → WAIT.
- WAIT:
  - On mem_rvalid, register the extracted value into rdata → DONE.
  - mem_rvalid is ignored in every state except WAIT.
- DONE: done = 1 for exactly one cycle, then → IDLE. misaligned clears on leaving DONE.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - Loads drive the same pattern.
- Store data:
  - SB replicates wdata[7:0] ×4.
  - SH replicates wdata[15:0] ×2.
  - SW passes wdata through.
- Load extraction:
  - Byte = mem_rdata[8·addr[1:0] +: 8].
  - Half = mem_rdata[16·addr[1] +: 16].
  - funct3 0/1 sign-extend; 4/5 zero-extend; 2 passes the word through.
- start while busy: ignored; no queuing.
- A faulted access leaves rdata unchanged.
- nReset low in any state, including mid-handshake, aborts to IDLE immediately. A late mem_gnt/mem_rvalid after reset is ignored.
- Reset values: state = IDLE. busy, done, misaligned, mem_req and mem_we = 0. rdata, mem_addr, mem_wdata = 0. mem_be = 0.

## Timing
- Cycle numbering: start sampled at edge 0.
- mem_req is high from cycle 1.
- Store, gnt at cycle g: done at g+1. Minimum: done at cycle 2.
- Load, gnt at cycle g, rvalid at cycle r > g: rdata valid and done = 1 at r+1. Minimum: gnt@1, rvalid@2, done@3.
- Faulted access: done and misaligned at cycle 1, mem_req never asserted.
- busy rises at cycle 1 and falls together with done.
- A new start is accepted in the cycle after done.
- No timeout; WAIT holds indefinitely.
- Memory contract: rvalid arrives at least one cycle after gnt.

## Test plan
- LB with addr = 0x1003, mem_rdata = 0x80AABBCC, gnt@1, rvalid@2 → mem_addr = 0x1000, mem_be = 4'b1000; done@3, rdata = 0xFFFFFF80.
- LHU with addr = 0x2002, mem_rdata = 0x9ABC1234, gnt delayed to cycle 4, rvalid@6 → mem_req held cycles 1–4 with stable address; done@7, rdata = 0x00009ABC.
- SB with addr = 0x11, wdata = 0x123456A5, gnt@1 → mem_we = 1, mem_be = 4'b0010, mem_wdata = 0xA5A5A5A5; done@2; rdata unchanged.
- Faults:
  - LW with addr = 0x3002 → done@1, misaligned = 1, mem_req never high.
  - Load funct3 = 3 → same response.
  - SH with addr = 0x5 → same response.
- Busy/reset:
  - start pulsed during WAIT → ignored, exactly one transaction.
  - nReset low during REQ → mem_req = 0 and busy = 0 immediately.
  - After reset release, a stale rvalid produces no done.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage, one data-memory transaction per start over req/gnt/rvalid
//   Clock, nReset        : clock, asynchronous active-low reset
//   start/is_store/funct3: request strobe (sampled in IDLE), store flag, RV32I width/sign code
//   addr, wdata          : effective address, store data
//   busy/done/misaligned : status, one-cycle completion pulse, fault flag valid with done
//   rdata                : extended load result, held until the next successful load
//   mem_*                : registered memory request side and returned read data
module load_store_unit #(
   parameter int dataW = 32
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             start,
   input  logic             is_store,
   input  logic [2:0]       funct3,
   input  logic [dataW-1:0] addr,
   input  logic [dataW-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             misaligned,
   output logic [dataW-1:0] rdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [dataW-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [dataW-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [dataW-1:0] mem_rdata
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0]       state;
   logic             st_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             fault;
   logic [3:0]       be_n;
   logic [dataW-1:0] wd_n, lane, ld;
   always_comb begin
      fault = (is_store ? (funct3 > 3'd2) : (funct3[1:0] == 2'd3 || funct3 == 3'd6))
            || (funct3[1:0] == 2'd1 && addr[0])
            || (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
      be_n  = funct3[1:0] == 2'd0 ? 4'b0001 << addr[1:0]
            : funct3[1:0] == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd_n  = funct3[1:0] == 2'd0 ? {4{wdata[7:0]}}
            : funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
      // halves are always 2-byte aligned here, so one byte-offset shift serves both widths
      lane  = mem_rdata >> {off_q, 3'b000};
      ld    = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]}
            : f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : mem_rdata;
   end
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         st_q       <= 1'b0;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         rdata      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= 4'd0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               st_q       <= is_store;
               f3_q       <= funct3;
               off_q      <= addr[1:0];
               mem_addr   <= {addr[dataW-1:2], 2'b00};
               mem_be     <= be_n;
               mem_wdata  <= wd_n;
               mem_we     <= is_store & ~fault;
               mem_req    <= ~fault;
               busy       <= 1'b1;
               done       <= fault;
               misaligned <= fault;
               state      <= fault ? DONE : REQ;
            end
            REQ: if (mem_gnt) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               done    <= st_q;
               state   <= st_q ? DONE : WAIT;
            end
            WAIT: if (mem_rvalid) begin
               rdata <= ld;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done       <= 1'b0;
               misaligned <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a behavioural LSU model and a reactive memory
module tb_load_store_unit;
   logic        Clock = 0, nReset = 1, start = 0, is_store = 0;
   logic [2:0]  funct3 = 0;
   logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
   logic        mem_gnt = 0, mem_rvalid = 0;
   logic        busy, done, misaligned, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   int total = 0, bad = 0, cyc = 0;
   bit auto_on = 0, dead = 0;
   typedef struct {bit misal; logic [31:0] rdata; int cyc;} exp_t;
   typedef struct {logic [31:0] addr, wdata, rword; logic [3:0] be; bit we; int gdly, rdly;} mem_t;
   exp_t exp_q[$];
   mem_t mq[$];
   exp_t ee;
   mem_t mm;
   logic [31:0] model_rdata = 0;

   load_store_unit #(.dataW(32)) dut (
      .Clock(Clock), .nReset(nReset), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misaligned(misaligned),
      .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // access size n bytes = 2**(funct3%4); legal when aligned to n and the code exists
   function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a, wd, rw,
                                 output bit flt, output logic [3:0] be, output logic [31:0] wo, ld);
      int n = 1 << (f3 % 4);
      int off = a % 4;
      logic [31:0] mask;
      flt = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
      if (off % n != 0) flt = 1;
      be = 4'(((1 << n) - 1) << off);
      wo = 0;
      for (int i = 0; i < 4; i++) wo[8*i +: 8] = wd[8*(i % n) +: 8];
      mask = (n >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
      ld = (rw >> (8 * off)) & mask;
      if (f3 < 4 && n < 4 && ld[8*n-1]) ld = ld | ~mask;
   endfunction

   task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, wd, rw,
                        input int gd, rd, input bit jnk);
      bit flt;
      logic [3:0] be;
      logic [31:0] wo, ld;
      exp_t e;
      mem_t m;
      int nd, w;
      model(st, f3, a, wd, rw, flt, be, wo, ld);
      if (!flt && !st) model_rdata = ld;
      nd = flt ? 1 : st ? 2 + gd : 3 + gd + rd;
      e.misal = flt; e.rdata = model_rdata; e.cyc = cyc + nd;
      if (!flt) begin
         m.addr = {a[31:2], 2'b00}; m.wdata = wo; m.rword = rw; m.be = be; m.we = st;
         m.gdly = gd; m.rdly = rd;
         mq.push_back(m);
      end
      exp_q.push_back(e);
      start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      @(posedge Clock); #1;
      if (jnk) begin
         // start held through the done cycle must never launch a second access
         start = 1; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
         repeat (nd) begin @(posedge Clock); #1; end
      end
      start = 0;
      w = 0;
      while ((exp_q.size() != 0 || busy) && w < 300) begin @(posedge Clock); #1; w++; end
      if (w >= 300) begin
         total++; bad++; dead = 1;
         $display("FAIL timeout: transaction still pending after %0d cycles", w);
      end
   endtask

   // memory responder: checks the request, grants after gdly cycles, returns data rdly cycles later
   initial forever begin
      @(negedge Clock);
      if (auto_on && mem_req) begin
         if (mq.size() == 0) chk("unexpected_req", 32'(mem_req), 0);
         else begin
            mm = mq.pop_front();
            for (int i = 0; i <= mm.gdly; i++) begin
               if (i > 0) @(negedge Clock);
               chk("req_held", 32'(mem_req), 1);
               chk("mem_addr", mem_addr, mm.addr);
               chk("mem_be", 32'(mem_be), 32'(mm.be));
               chk("mem_we", 32'(mem_we), 32'(mm.we));
               if (mm.we) chk("mem_wdata", mem_wdata, mm.wdata);
            end
            mem_gnt = 1;
            @(negedge Clock);
            mem_gnt = 0;
            chk("req_drop", 32'(mem_req), 0);
            if (!mm.we) begin
               repeat (mm.rdly) @(negedge Clock);
               mem_rvalid = 1; mem_rdata = mm.rword;
               @(negedge Clock);
               mem_rvalid = 0; mem_rdata = $urandom;
            end
         end
      end
   end

   // completion monitor
   initial forever begin
      @(negedge Clock);
      if (auto_on && done) begin
         if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 0);
         else begin
            ee = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(ee.cyc));
            chk("misaligned", 32'(misaligned), 32'(ee.misal));
            chk("rdata", rdata, ee.rdata);
            chk("busy_at_done", 32'(busy), 1);
         end
      end
   end

   initial begin
      #2 nReset = 0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_misaligned", 32'(misaligned), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", 32'(mem_be), 0);
      nReset = 1;
      @(posedge Clock); #1;
      start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h100;
      @(posedge Clock); #1;
      start = 0;
      @(negedge Clock);
      chk("abort_req_before", 32'(mem_req), 1);
      nReset = 0;
      #1;
      chk("abort_mem_req", 32'(mem_req), 0);
      chk("abort_busy", 32'(busy), 0);
      @(posedge Clock); #1;
      nReset = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge Clock); #1;
         mem_gnt = (i == 0); mem_rvalid = (i > 0 && i < 3); mem_rdata = $urandom;
         @(negedge Clock);
         chk("stale_done", 32'(done), 0);
         chk("stale_busy", 32'(busy), 0);
         chk("stale_req", 32'(mem_req), 0);
         chk("stale_rdata", rdata, 0);
      end
      @(posedge Clock); #1;
      mem_gnt = 0; mem_rvalid = 0;
      auto_on = 1;
      issue(0, 3'd0, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0);
      issue(0, 3'd5, 32'h2002, 32'h0, 32'h9ABC1234, 3, 1, 0);
      issue(1, 3'd0, 32'h11, 32'h123456A5, 32'h0, 0, 0, 0);
      issue(0, 3'd2, 32'h3002, 32'h0, 32'h0, 0, 0, 0);
      issue(0, 3'd3, 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      issue(1, 3'd1, 32'h5, 32'hCAFE, 32'h0, 0, 0, 0);
      issue(0, 3'd1, 32'h6, 32'h0, 32'h8001_7FFF, 0, 4, 1);
      for (int i = 0; i < 200 && !dead; i++) begin
         bit st;
         logic [2:0] f3;
         logic [31:0] a;
         st = 1'($urandom);
         f3 = 3'($urandom);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
         issue(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end
      repeat (5) @(negedge Clock);
      chk("exp_left", 32'(exp_q.size()), 0);
      chk("mem_left", 32'(mq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
